// File: rtl/pipe_buffer.sv
// pipe_buffer: elastic pipeline-stage register with a two-entry skid store.
// Carries FIELDS words of WIDTH bits between two pipeline stages. It has a
// valid/ready handshake, a stage flush that inserts a bubble, and a
// synchronous active-low reset. All outputs come straight from flops, so
// there is no combinational path from outReady to inReady.
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst_n     synchronous active-low reset (priority over flush/handshakes)
//   flush     synchronous stage flush, empties the stage and loads NOP fields
//   inValid   upstream offers inData
//   inReady   stage can accept (registered)
//   inData    FIELDS*WIDTH payload, field k at [k*WIDTH +: WIDTH]
//   outValid  outData holds a valid entry (registered)
//   outReady  downstream accepts
//   outData   head entry, driven directly from the main register
//   level     occupancy 0..2 (registered)
module pipe_buffer #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       FIELDS  = 3,
    parameter logic [WIDTH-1:0]  NOP_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [FIELDS*WIDTH-1:0]   inData,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [FIELDS*WIDTH-1:0]   outData,
    output logic [1:0]                level
);

    localparam int unsigned DW = FIELDS * WIDTH;
    localparam logic [DW-1:0] NOP_FILL = {FIELDS{NOP_VAL}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_nxt;
    logic [DW-1:0]   main_q, main_nxt;
    logic [DW-1:0]   skid_q, skid_nxt;
    logic            in_ready_q, in_ready_nxt;
    logic            out_valid_q, out_valid_nxt;
    logic [1:0]      level_q, level_nxt;

    logic            in_fire;
    logic            out_fire;

    assign in_fire  = inValid & in_ready_q;
    assign out_fire = out_valid_q & outReady;

    // State and storage registers; status outputs are re-registered from
    // the next state so they never depend combinationally on outReady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= NOP_FILL;
            skid_q      <= NOP_FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
        end else begin
            state_q     <= state_nxt;
            main_q      <= main_nxt;
            skid_q      <= skid_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
            level_q     <= level_nxt;
        end
    end

    // Next-state, storage update and next-cycle status decode.
    always_comb begin
        state_nxt     = state_q;
        main_nxt      = main_q;
        skid_nxt      = skid_q;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
        level_nxt     = 2'd0;

        if (flush) begin
            // Handshakes in the flush cycle are dropped on the floor.
            state_nxt = EMPTY;
            main_nxt  = NOP_FILL;
            skid_nxt  = NOP_FILL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = inData;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = inData;
                    end else if (in_fire) begin
                        skid_nxt  = inData;
                        state_nxt = FULL;
                    end else if (out_fire) begin
                        // main keeps its last value while empty
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_fire is impossible here since inReady is low
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end

        in_ready_nxt  = (state_nxt != FULL);
        out_valid_nxt = (state_nxt != EMPTY);
        case (state_nxt)
            ONE:     level_nxt = 2'd1;
            FULL:    level_nxt = 2'd2;
            default: level_nxt = 2'd0;
        endcase
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign outData  = main_q;
    assign level    = level_q;

endmodule
